// File: rtl/mem_stage_pkg.sv
// Shared constants, opcode decode and FSM encoding for the MEM pipeline stage.
package mem_stage_pkg;

    localparam int unsigned DEFAULT_WIDTH   = 32;
    localparam int unsigned DEFAULT_TIMEOUT = 16;
    localparam int unsigned OP_W            = 6;

    localparam logic [OP_W-1:0] OP_LOAD  = 6'b100011;
    localparam logic [OP_W-1:0] OP_STORE = 6'b101011;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // True for opcodes that touch data memory.
    function automatic logic is_mem_op(input logic [OP_W-1:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    // True for the store opcode.
    function automatic logic is_store_op(input logic [OP_W-1:0] op);
        return op == OP_STORE;
    endfunction

endpackage : mem_stage_pkg

// File: rtl/mem_stage.sv
// MEM pipeline stage: passes ALU results through in one cycle, performs
// word-aligned loads/stores over a req/ack data-memory port with a bounded
// wait, and flags misaligned accesses and memory timeouts on err_out.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   IR_in,
    input  logic [WIDTH-3:0]   PC_in,
    input  logic [WIDTH-1:0]   Z_in,
    input  logic [WIDTH-1:0]   Addr_in,

    output logic               dmem_req,
    output logic               dmem_we,
    output logic [WIDTH-1:0]   dmem_addr,
    output logic [WIDTH-1:0]   dmem_wdata,
    input  logic               dmem_ack,
    input  logic [WIDTH-1:0]   dmem_rdata,

    output logic               out_valid,
    output logic [WIDTH-1:0]   IR_out,
    output logic [WIDTH-3:0]   PC_out,
    output logic [WIDTH-1:0]   Res_out,
    output logic               err_out
);

    localparam int unsigned PC_W  = WIDTH - 2;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t state_q;
    state_t state_next;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Instruction captured at accept, replayed to MEM_WB when the access ends.
    logic [WIDTH-1:0] ir_cap_q;
    logic [WIDTH-1:0] ir_cap_d;
    logic [PC_W-1:0]  pc_cap_q;
    logic [PC_W-1:0]  pc_cap_d;
    logic [WIDTH-1:0] z_cap_q;
    logic [WIDTH-1:0] z_cap_d;
    logic             store_cap_q;
    logic             store_cap_d;

    // Next values of the registered outputs.
    logic             req_d;
    logic             we_d;
    logic [WIDTH-1:0] addr_d;
    logic [WIDTH-1:0] wdata_d;
    logic             out_valid_d;
    logic [WIDTH-1:0] ir_out_d;
    logic [PC_W-1:0]  pc_out_d;
    logic [WIDTH-1:0] res_d;
    logic             err_d;

    // Decode of the incoming instruction.
    logic [OP_W-1:0] op_c;
    logic            mem_op_c;
    logic            store_op_c;
    logic            aligned_c;
    logic            accept_c;
    logic            timeout_c;

    assign op_c       = IR_in[WIDTH-1 -: OP_W];
    assign mem_op_c   = is_mem_op(op_c);
    assign store_op_c = is_store_op(op_c);
    assign aligned_c  = (Addr_in[1:0] == 2'b00);
    assign in_ready   = (state_q == ST_IDLE) && rst_n;
    assign accept_c   = in_valid && in_ready;
    assign timeout_c  = (cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state logic: only an aligned memory op leaves IDLE; ack or timeout returns.
    always_comb begin
        state_next = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept_c && mem_op_c && aligned_c) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (dmem_ack || timeout_c) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic: next values for the memory request, wait counter and MEM_WB outputs.
    always_comb begin
        cnt_d       = cnt_q;
        ir_cap_d    = ir_cap_q;
        pc_cap_d    = pc_cap_q;
        z_cap_d     = z_cap_q;
        store_cap_d = store_cap_q;
        req_d       = dmem_req;
        we_d        = dmem_we;
        addr_d      = dmem_addr;
        wdata_d     = dmem_wdata;
        out_valid_d = 1'b0;
        ir_out_d    = IR_out;
        pc_out_d    = PC_out;
        res_d       = Res_out;
        err_d       = err_out;

        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    ir_cap_d    = IR_in;
                    pc_cap_d    = PC_in;
                    z_cap_d     = Z_in;
                    store_cap_d = store_op_c;
                    if (mem_op_c && aligned_c) begin
                        req_d   = 1'b1;
                        we_d    = store_op_c;
                        addr_d  = Addr_in;
                        wdata_d = Z_in;
                        cnt_d   = '0;
                    end else begin
                        // Non-memory pass-through, or misaligned access reported as an error.
                        out_valid_d = 1'b1;
                        ir_out_d    = IR_in;
                        pc_out_d    = PC_in;
                        err_d       = mem_op_c;
                        res_d       = mem_op_c ? '0 : Z_in;
                    end
                end
            end
            ST_ACCESS: begin
                if (dmem_ack) begin
                    // Ack wins over a coincident timeout.
                    req_d       = 1'b0;
                    we_d        = 1'b0;
                    out_valid_d = 1'b1;
                    ir_out_d    = ir_cap_q;
                    pc_out_d    = pc_cap_q;
                    err_d       = 1'b0;
                    res_d       = store_cap_q ? z_cap_q : dmem_rdata;
                end else if (timeout_c) begin
                    req_d       = 1'b0;
                    we_d        = 1'b0;
                    out_valid_d = 1'b1;
                    ir_out_d    = ir_cap_q;
                    pc_out_d    = pc_cap_q;
                    err_d       = 1'b1;
                    res_d       = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                req_d = 1'b0;
                we_d  = 1'b0;
            end
        endcase
    end

    // Output and capture registers; reset clears everything, aborting any access.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            ir_cap_q    <= '0;
            pc_cap_q    <= '0;
            z_cap_q     <= '0;
            store_cap_q <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            out_valid   <= 1'b0;
            IR_out      <= '0;
            PC_out      <= '0;
            Res_out     <= '0;
            err_out     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            ir_cap_q    <= ir_cap_d;
            pc_cap_q    <= pc_cap_d;
            z_cap_q     <= z_cap_d;
            store_cap_q <= store_cap_d;
            dmem_req    <= req_d;
            dmem_we     <= we_d;
            dmem_addr   <= addr_d;
            dmem_wdata  <= wdata_d;
            out_valid   <= out_valid_d;
            IR_out      <= ir_out_d;
            PC_out      <= pc_out_d;
            Res_out     <= res_d;
            err_out     <= err_d;
        end
    end

endmodule : mem_stage

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: pass-through, loads/stores, misalignment,
// timeout, ack/timeout collision, reset abort and back-to-back throughput.
module tb_mem_stage;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned TIMEOUT = 16;

    localparam logic [31:0] IR_ADD   = 32'h0022_1820;
    localparam logic [31:0] IR_LOAD  = 32'h8C22_0004;
    localparam logic [31:0] IR_STORE = 32'hAC22_0008;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  IR_in;
    logic [WIDTH-3:0]  PC_in;
    logic [WIDTH-1:0]  Z_in;
    logic [WIDTH-1:0]  Addr_in;
    logic              dmem_req;
    logic              dmem_we;
    logic [WIDTH-1:0]  dmem_addr;
    logic [WIDTH-1:0]  dmem_wdata;
    logic              dmem_ack;
    logic [WIDTH-1:0]  dmem_rdata;
    logic              out_valid;
    logic [WIDTH-1:0]  IR_out;
    logic [WIDTH-3:0]  PC_out;
    logic [WIDTH-1:0]  Res_out;
    logic              err_out;

    int nvec;
    int nerr;

    mem_stage #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .IR_in      (IR_in),
        .PC_in      (PC_in),
        .Z_in       (Z_in),
        .Addr_in    (Addr_in),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .out_valid  (out_valid),
        .IR_out     (IR_out),
        .PC_out     (PC_out),
        .Res_out    (Res_out),
        .err_out    (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled and inputs driven 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ir, input logic [29:0] pc,
                         input logic [31:0] z, input logic [31:0] addr);
        in_valid = 1'b1;
        IR_in    = ir;
        PC_in    = pc;
        Z_in     = z;
        Addr_in  = addr;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        nvec++; if (dmem_req !== 1'b0) begin nerr++; $display("FAIL rst_req got %b exp 0", dmem_req); end
        nvec++; if (dmem_we !== 1'b0) begin nerr++; $display("FAIL rst_we got %b exp 0", dmem_we); end
        nvec++; if (dmem_addr !== 32'h0) begin nerr++; $display("FAIL rst_addr got %h exp 0", dmem_addr); end
        nvec++; if (dmem_wdata !== 32'h0) begin nerr++; $display("FAIL rst_wdata got %h exp 0", dmem_wdata); end
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        nvec++; if (err_out !== 1'b0) begin nerr++; $display("FAIL rst_err got %b exp 0", err_out); end
        nvec++; if (IR_out !== 32'h0) begin nerr++; $display("FAIL rst_ir got %h exp 0", IR_out); end
        nvec++; if (PC_out !== 30'h0) begin nerr++; $display("FAIL rst_pc got %h exp 0", PC_out); end
        nvec++; if (Res_out !== 32'h0) begin nerr++; $display("FAIL rst_res got %h exp 0", Res_out); end
        rst_n = 1'b1;
        #1;
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL rst_release_ready got %b exp 1", in_ready); end
        tick();
    endtask

    task automatic test_alu();
        drive(IR_ADD, 30'h10, 32'h1234, 32'h55);
        tick();
        in_valid = 1'b0;
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL alu_valid got %b exp 1", out_valid); end
        nvec++; if (Res_out !== 32'h1234) begin nerr++; $display("FAIL alu_res got %h exp 1234", Res_out); end
        nvec++; if (err_out !== 1'b0) begin nerr++; $display("FAIL alu_err got %b exp 0", err_out); end
        nvec++; if (IR_out !== IR_ADD) begin nerr++; $display("FAIL alu_ir got %h exp %h", IR_out, IR_ADD); end
        nvec++; if (PC_out !== 30'h10) begin nerr++; $display("FAIL alu_pc got %h exp 10", PC_out); end
        nvec++; if (dmem_req !== 1'b0) begin nerr++; $display("FAIL alu_req got %b exp 0", dmem_req); end
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL alu_ready got %b exp 1", in_ready); end
        tick();
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL alu_pulse got %b exp 0", out_valid); end
        nvec++; if (Res_out !== 32'h1234) begin nerr++; $display("FAIL alu_hold got %h exp 1234", Res_out); end
    endtask

    task automatic test_load_wait();
        drive(IR_LOAD, 30'h20, 32'h999, 32'h100);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nvec++; if (dmem_req !== 1'b1) begin nerr++; $display("FAIL ld_req[%0d] got %b exp 1", i, dmem_req); end
            nvec++; if (dmem_addr !== 32'h100) begin nerr++; $display("FAIL ld_addr[%0d] got %h exp 100", i, dmem_addr); end
            nvec++; if (dmem_we !== 1'b0) begin nerr++; $display("FAIL ld_we[%0d] got %b exp 0", i, dmem_we); end
            nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL ld_ready[%0d] got %b exp 0", i, in_ready); end
            nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL ld_early_valid[%0d] got %b exp 0", i, out_valid); end
            if (i == 2) begin
                dmem_ack   = 1'b1;
                dmem_rdata = 32'hCAFE_BABE;
            end
            tick();
        end
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL ld_valid got %b exp 1", out_valid); end
        nvec++; if (Res_out !== 32'hCAFE_BABE) begin nerr++; $display("FAIL ld_res got %h exp cafebabe", Res_out); end
        nvec++; if (err_out !== 1'b0) begin nerr++; $display("FAIL ld_err got %b exp 0", err_out); end
        nvec++; if (IR_out !== IR_LOAD) begin nerr++; $display("FAIL ld_ir got %h exp %h", IR_out, IR_LOAD); end
        nvec++; if (PC_out !== 30'h20) begin nerr++; $display("FAIL ld_pc got %h exp 20", PC_out); end
        nvec++; if (dmem_req !== 1'b0) begin nerr++; $display("FAIL ld_req_drop got %b exp 0", dmem_req); end
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL ld_ready_back got %b exp 1", in_ready); end
        tick();
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL ld_pulse got %b exp 0", out_valid); end
    endtask

    task automatic test_store();
        drive(IR_STORE, 30'h30, 32'hDEAD, 32'h104);
        tick();
        in_valid = 1'b0;
        nvec++; if (dmem_req !== 1'b1) begin nerr++; $display("FAIL st_req got %b exp 1", dmem_req); end
        nvec++; if (dmem_we !== 1'b1) begin nerr++; $display("FAIL st_we got %b exp 1", dmem_we); end
        nvec++; if (dmem_wdata !== 32'hDEAD) begin nerr++; $display("FAIL st_wdata got %h exp dead", dmem_wdata); end
        nvec++; if (dmem_addr !== 32'h104) begin nerr++; $display("FAIL st_addr got %h exp 104", dmem_addr); end
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1111_1111;
        tick();
        dmem_ack   = 1'b0;
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL st_valid got %b exp 1", out_valid); end
        nvec++; if (err_out !== 1'b0) begin nerr++; $display("FAIL st_err got %b exp 0", err_out); end
        nvec++; if (Res_out !== 32'hDEAD) begin nerr++; $display("FAIL st_res got %h exp dead", Res_out); end
        nvec++; if (dmem_req !== 1'b0) begin nerr++; $display("FAIL st_req_drop got %b exp 0", dmem_req); end
        nvec++; if (dmem_we !== 1'b0) begin nerr++; $display("FAIL st_we_drop got %b exp 0", dmem_we); end
        tick();
    endtask

    task automatic test_misaligned();
        drive(IR_LOAD, 30'h40, 32'h77, 32'h102);
        tick();
        in_valid = 1'b0;
        nvec++; if (dmem_req !== 1'b0) begin nerr++; $display("FAIL mis_req got %b exp 0", dmem_req); end
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL mis_valid got %b exp 1", out_valid); end
        nvec++; if (err_out !== 1'b1) begin nerr++; $display("FAIL mis_err got %b exp 1", err_out); end
        nvec++; if (Res_out !== 32'h0) begin nerr++; $display("FAIL mis_res got %h exp 0", Res_out); end
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL mis_ready got %b exp 1", in_ready); end
        tick();
    endtask

    task automatic test_ack_ignored();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hBAD0_BAD0;
        tick();
        tick();
        dmem_ack = 1'b0;
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL idle_ack_valid got %b exp 0", out_valid); end
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL idle_ack_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_timeout();
        int n;
        drive(IR_LOAD, 30'h50, 32'h0, 32'h200);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (dmem_req === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        nvec++; if (n !== 16) begin nerr++; $display("FAIL to_req_cycles got %0d exp 16", n); end
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL to_valid got %b exp 1", out_valid); end
        nvec++; if (err_out !== 1'b1) begin nerr++; $display("FAIL to_err got %b exp 1", err_out); end
        nvec++; if (Res_out !== 32'h0) begin nerr++; $display("FAIL to_res got %h exp 0", Res_out); end
        nvec++; if (PC_out !== 30'h50) begin nerr++; $display("FAIL to_pc got %h exp 50", PC_out); end
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL to_ready got %b exp 1", in_ready); end
        tick();
    endtask

    task automatic test_ack_at_timeout();
        drive(IR_LOAD, 30'h60, 32'h0, 32'h300);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        nvec++; if (dmem_req !== 1'b1) begin nerr++; $display("FAIL col_req got %b exp 1", dmem_req); end
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h5A5A_5A5A;
        tick();
        dmem_ack = 1'b0;
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL col_valid got %b exp 1", out_valid); end
        nvec++; if (err_out !== 1'b0) begin nerr++; $display("FAIL col_err got %b exp 0", err_out); end
        nvec++; if (Res_out !== 32'h5A5A_5A5A) begin nerr++; $display("FAIL col_res got %h exp 5a5a5a5a", Res_out); end
        tick();
    endtask

    task automatic test_reset_mid();
        drive(IR_LOAD, 30'h70, 32'h0, 32'h400);
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        nvec++; if (dmem_req !== 1'b0) begin nerr++; $display("FAIL rmid_req got %b exp 0", dmem_req); end
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rmid_valid got %b exp 0", out_valid); end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rmid_stray_valid[%0d] got %b exp 0", i, out_valid); end
        end
        drive(IR_ADD, 30'h71, 32'h77, 32'h0);
        tick();
        in_valid = 1'b0;
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL rmid_add_valid got %b exp 1", out_valid); end
        nvec++; if (Res_out !== 32'h77) begin nerr++; $display("FAIL rmid_add_res got %h exp 77", Res_out); end
        nvec++; if (err_out !== 1'b0) begin nerr++; $display("FAIL rmid_add_err got %b exp 0", err_out); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] irs [4];
        logic [31:0] exp_res;
        logic        exp_err;
        irs[0] = IR_ADD;
        irs[1] = 32'h0043_2022;
        irs[2] = IR_STORE;
        irs[3] = 32'h3C01_0010;
        for (int i = 0; i < 4; i++) begin
            // Entry 2 is a misaligned store, so it completes in one cycle with an error.
            drive(irs[i], 30'(32'h80 + i), 32'(32'h100 + i), 32'h3);
            exp_res = (i == 2) ? 32'h0 : 32'(32'h100 + i);
            exp_err = (i == 2);
            tick();
            nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL b2b_valid[%0d] got %b exp 1", i, out_valid); end
            nvec++; if (Res_out !== exp_res) begin nerr++; $display("FAIL b2b_res[%0d] got %h exp %h", i, Res_out, exp_res); end
            nvec++; if (err_out !== exp_err) begin nerr++; $display("FAIL b2b_err[%0d] got %b exp %b", i, err_out, exp_err); end
            nvec++; if (IR_out !== irs[i]) begin nerr++; $display("FAIL b2b_ir[%0d] got %h exp %h", i, IR_out, irs[i]); end
            nvec++; if (PC_out !== 30'(32'h80 + i)) begin nerr++; $display("FAIL b2b_pc[%0d] got %h", i, PC_out); end
            nvec++; if (dmem_req !== 1'b0) begin nerr++; $display("FAIL b2b_req[%0d] got %b exp 0", i, dmem_req); end
        end
        in_valid = 1'b0;
        tick();
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL b2b_end got %b exp 0", out_valid); end
    endtask

    initial begin
        nvec       = 0;
        nerr       = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        IR_in      = '0;
        PC_in      = '0;
        Z_in       = '0;
        Addr_in    = '0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        #1;
        test_reset();
        test_alu();
        test_load_wait();
        test_store();
        test_misaligned();
        test_ack_ignored();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule : tb_mem_stage

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, as the datapath width (shared `WIDTH from params.v).
REQ-002 The block SHALL have parameter TIMEOUT, default 16, as the maximum cycles to wait for dmem_ack.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-004 The block SHALL have port rst_n, input, 1, a synchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1, meaning the EXE_MEM register holds a valid instruction.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the stage accepts an instruction this cycle (stall when 0).
REQ-007 The block SHALL have ports IR_in (WIDTH), PC_in (WIDTH-2), Z_in (WIDTH, ALU result / store data) and Addr_in (WIDTH, effective address), all inputs fed from the EXE_MEM outputs.
REQ-008 The block SHALL have ports dmem_req (1), dmem_we (1), dmem_addr (WIDTH) and dmem_wdata (WIDTH), all outputs forming the data-memory request.
REQ-009 The block SHALL have ports dmem_ack (1) and dmem_rdata (WIDTH), inputs carrying the memory response; dmem_rdata is valid when dmem_ack=1.
REQ-010 The block SHALL have ports out_valid (1), IR_out (WIDTH), PC_out (WIDTH-2), Res_out (WIDTH) and err_out (1), outputs to MEM_WB.

Function
REQ-011 Opcode SHALL be IR_in[WIDTH-1:WIDTH-6]; OP_LOAD=6'b100011, OP_STORE=6'b101011; all other opcodes are non-memory.
REQ-012 The FSM SHALL have states IDLE and ACCESS; in_ready SHALL be 1 exactly when state=IDLE and rst_n=1.
REQ-013 Accept SHALL occur on an edge where in_valid=1 and in_ready=1; IR_in, PC_in, Z_in and Addr_in are captured.
REQ-014 For a non-memory accept, the stage SHALL stay in IDLE, and in the next cycle drive out_valid=1, Res_out=Z_in, err_out=0 (1-cycle latency).
REQ-015 For a load/store accept with Addr_in[1:0]=0, the FSM SHALL go to ACCESS with dmem_req=1, dmem_addr=Addr_in, dmem_we=(store), dmem_wdata=Z_in, all registered.
REQ-016 For a load/store accept with Addr_in[1:0]!=0, the stage SHALL issue no request, stay in IDLE, and in the next cycle drive out_valid=1, err_out=1, Res_out=0.
REQ-017 In ACCESS, dmem_req, dmem_we, dmem_addr and dmem_wdata SHALL hold stable until an edge with dmem_ack=1 or timeout.
REQ-018 On an edge in ACCESS with dmem_ack=1, the FSM SHALL return to IDLE, deassert dmem_req, and in the next cycle drive out_valid=1, err_out=0, Res_out=dmem_rdata (load) or Z_in (store).
REQ-019 A wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without ack; when it reaches TIMEOUT-1 without ack, the FSM SHALL return to IDLE with out_valid=1, err_out=1, Res_out=0.
REQ-020 Ack and timeout on the same edge SHALL resolve as ack (no error).
REQ-021 dmem_ack SHALL be ignored outside ACCESS.
REQ-022 out_valid SHALL be a single-cycle pulse per accepted instruction; IR_out and PC_out SHALL carry that instruction's captured IR and PC; Res_out, IR_out and PC_out SHALL hold their values while out_valid=0.
REQ-023 Minimum memory-op latency SHALL be 3 edges: accept, ack seen, out_valid high; back-to-back non-memory instructions SHALL sustain 1 per cycle.

Reset
REQ-024 While rst_n=0 at an edge: state=IDLE, counter=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, out_valid=0, err_out=0, IR_out=0, PC_out=0, Res_out=0.
REQ-025 Reset asserted mid-ACCESS SHALL drop dmem_req at that edge, and no out_valid SHALL be produced for the aborted instruction.

Structure
REQ-026 WIDTH, TIMEOUT default, OP_LOAD and OP_STORE SHALL be defined in the shared params.v include.
REQ-027 The block SHALL be one module with no sub-module; the counter and FSM are inline.

Verification
REQ-028 ADD (IR[31:26]=0), Z_in=0x1234 -> out_valid 1 cycle later, Res_out=0x1234, err_out=0, no dmem_req.
REQ-029 LOAD, Addr_in=0x100, ack after 2 wait cycles with rdata=0xCAFEBABE -> req held 3 cycles at addr 0x100, we=0; Res_out=0xCAFEBABE; in_ready=0 throughout.
REQ-030 STORE, Addr_in=0x104, Z_in=0xDEAD, ack immediately -> we=1, wdata=0xDEAD for 1 cycle; out_valid with err_out=0.
REQ-031 LOAD, Addr_in=0x102 -> no dmem_req; next cycle out_valid=1, err_out=1.
REQ-032 LOAD with no ack, TIMEOUT=16 -> req high 16 cycles, then out_valid=1, err_out=1, in_ready returns to 1.
REQ-033 rst_n=0 during ACCESS cycle 2 -> dmem_req=0 next cycle, no out_valid; a following ADD completes normally.
